// File: rtl/pc_unit.sv
// Program counter with hold, increment, jump, relative branch and a
// return-address stack for call/return. All state updates on the rising clock edge.
module pc_unit #(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  localparam int unsigned      DW           = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] imm,
  input  logic             taken,
  output logic [WIDTH-1:0] pc,
  output logic [DW-1:0]    depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             fault
);

  // Index width into the stack array; depth itself needs one extra code for "full".
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OpHold   = 3'b000,
    OpNext   = 3'b001,
    OpJump   = 3'b010,
    OpBranch = 3'b011,
    OpCall   = 3'b100,
    OpRet    = 3'b101
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             fault_q, fault_d;
  logic             push;
  logic [WIDTH-1:0] pc_inc;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             full, empty;

  // Return-address storage; contents are deliberately not reset.
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  assign pc_inc = pc_q + WIDTH'(1);
  assign full   = (depth_q == DW'(STACK_DEPTH));
  assign empty  = (depth_q == '0);
  // Both indices are only used when the guard (not full / not empty) holds.
  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - DW'(1));

  // Decode the operation into next pc, depth and fault.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    fault_d = fault_q;
    push    = 1'b0;
    if (en) begin
      unique case (op)
        OpHold:   pc_d = pc_q;
        OpNext:   pc_d = pc_inc;
        OpJump:   pc_d = imm;
        OpBranch: pc_d = taken ? (pc_q + imm) : pc_inc;
        OpCall: begin
          if (full) begin
            fault_d = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = imm;
            depth_d = depth_q + DW'(1);
          end
        end
        OpRet: begin
          if (empty) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = stack_q[rd_idx];
            depth_d = depth_q - DW'(1);
          end
        end
        default:  fault_d = 1'b1;
      endcase
    end
  end

  // Architectural state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  // Stack write on a successful call; no reset needed since depth gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (WIDTH=8, STACK_DEPTH=4, RESET_VECTOR=0xA0).
module tb_pc_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SD    = 4;
  localparam logic [7:0]  RV    = 8'hA0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] imm = 8'h00;
  logic       taken = 1'b0;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       stack_full, stack_empty, fault;

  int compared = 0;
  int mismatched = 0;

  pc_unit #(
    .WIDTH        (WIDTH),
    .STACK_DEPTH  (SD),
    .RESET_VECTOR (RV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .op          (op),
    .imm         (imm),
    .taken       (taken),
    .pc          (pc),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Drive one op at the falling edge, let it execute, settle 1 unit after the edge.
  task automatic step(input logic e, input logic [2:0] o, input logic [7:0] i, input logic t);
    @(negedge clk);
    en = e; op = o; imm = i; taken = t;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed away from both clock edges.
  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if (pc !== RV) begin
      mismatched++; $display("FAIL reset_pc: got %h want %h", pc, RV);
    end
    compared++;
    if (depth !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_stack: got depth=%0d empty=%b full=%b want 0 1 0",
               depth, stack_empty, stack_full);
    end
    compared++;
    if (fault !== 1'b0) begin
      mismatched++; $display("FAIL reset_fault: got %b want 0", fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b0, 3'b001, 8'h00, 1'b0);
    compared++;
    if (pc !== RV) begin
      mismatched++; $display("FAIL stall_pc: got %h want %h", pc, RV);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 3'b010, 8'hFE, 1'b0);
    step(1'b1, 3'b001, 8'h00, 1'b0);
    compared++;
    if (pc !== 8'hFF) begin
      mismatched++; $display("FAIL wrap_ff: got %h want ff", pc);
    end
    step(1'b1, 3'b001, 8'h00, 1'b0);
    compared++;
    if (pc !== 8'h00) begin
      mismatched++; $display("FAIL wrap_00: got %h want 00", pc);
    end
  endtask

  task automatic test_branch();
    step(1'b1, 3'b010, 8'h10, 1'b0);
    step(1'b1, 3'b011, 8'hFE, 1'b1);
    compared++;
    if (pc !== 8'h0E) begin
      mismatched++; $display("FAIL branch_taken: got %h want 0e", pc);
    end
    step(1'b1, 3'b010, 8'h10, 1'b0);
    step(1'b1, 3'b011, 8'hFE, 1'b0);
    compared++;
    if (pc !== 8'h11) begin
      mismatched++; $display("FAIL branch_not_taken: got %h want 11", pc);
    end
    step(1'b1, 3'b010, 8'h40, 1'b1);
    compared++;
    if (pc !== 8'h40) begin
      mismatched++; $display("FAIL jump: got %h want 40", pc);
    end
    // taken must be ignored outside BRANCH
    step(1'b1, 3'b001, 8'h55, 1'b1);
    compared++;
    if (pc !== 8'h41) begin
      mismatched++; $display("FAIL next_ignores_taken: got %h want 41", pc);
    end
  endtask

  task automatic test_nested_calls();
    step(1'b1, 3'b010, 8'h05, 1'b0);
    step(1'b1, 3'b100, 8'h20, 1'b0);
    compared++;
    if (pc !== 8'h20 || depth !== 3'd1) begin
      mismatched++; $display("FAIL call1: got pc=%h depth=%0d want 20 1", pc, depth);
    end
    step(1'b1, 3'b100, 8'h30, 1'b0);
    compared++;
    if (pc !== 8'h30 || depth !== 3'd2) begin
      mismatched++; $display("FAIL call2: got pc=%h depth=%0d want 30 2", pc, depth);
    end
    step(1'b1, 3'b101, 8'h00, 1'b0);
    compared++;
    if (pc !== 8'h21 || depth !== 3'd1) begin
      mismatched++; $display("FAIL ret1: got pc=%h depth=%0d want 21 1", pc, depth);
    end
    step(1'b1, 3'b101, 8'h00, 1'b0);
    compared++;
    if (pc !== 8'h06 || depth !== 3'd0 || fault !== 1'b0) begin
      mismatched++;
      $display("FAIL ret2: got pc=%h depth=%0d fault=%b want 06 0 0", pc, depth, fault);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h31, 8'h21, 8'h11, 8'hA1};
    do_reset();
    step(1'b1, 3'b100, 8'h10, 1'b0);
    step(1'b1, 3'b100, 8'h20, 1'b0);
    step(1'b1, 3'b100, 8'h30, 1'b0);
    step(1'b1, 3'b100, 8'h40, 1'b0);
    compared++;
    if (pc !== 8'h40 || depth !== 3'd4 || stack_full !== 1'b1 || fault !== 1'b0) begin
      mismatched++;
      $display("FAIL call4: got pc=%h depth=%0d full=%b fault=%b want 40 4 1 0",
               pc, depth, stack_full, fault);
    end
    step(1'b1, 3'b100, 8'h50, 1'b0);
    compared++;
    if (pc !== 8'h40 || depth !== 3'd4 || stack_full !== 1'b1 || fault !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow: got pc=%h depth=%0d full=%b fault=%b want 40 4 1 1",
               pc, depth, stack_full, fault);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 3'b101, 8'h00, 1'b0);
      compared++;
      if (pc !== exp_ret[k] || depth !== 3'(3 - k)) begin
        mismatched++;
        $display("FAIL unwind%0d: got pc=%h depth=%0d want %h %0d",
                 k, pc, depth, exp_ret[k], 3 - k);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, 3'b101, 8'h00, 1'b0);
    compared++;
    if (pc !== RV || depth !== 3'd0 || fault !== 1'b1) begin
      mismatched++;
      $display("FAIL underflow: got pc=%h depth=%0d fault=%b want %h 0 1", pc, depth, fault, RV);
    end
    step(1'b1, 3'b001, 8'h00, 1'b0);
    step(1'b1, 3'b001, 8'h00, 1'b0);
    compared++;
    if (pc !== 8'hA2 || fault !== 1'b1) begin
      mismatched++; $display("FAIL after_fault: got pc=%h fault=%b want a2 1", pc, fault);
    end
  endtask

  task automatic test_reserved();
    do_reset();
    step(1'b0, 3'b110, 8'h00, 1'b0);
    step(1'b0, 3'b100, 8'h33, 1'b0);
    compared++;
    if (pc !== RV || fault !== 1'b0 || depth !== 3'd0) begin
      mismatched++;
      $display("FAIL reserved_stalled: got pc=%h fault=%b depth=%0d want %h 0 0",
               pc, fault, depth, RV);
    end
    step(1'b1, 3'b110, 8'h77, 1'b1);
    compared++;
    if (pc !== RV || fault !== 1'b1) begin
      mismatched++; $display("FAIL reserved_110: got pc=%h fault=%b want %h 1", pc, fault, RV);
    end
    do_reset();
    step(1'b1, 3'b111, 8'h77, 1'b0);
    compared++;
    if (pc !== RV || fault !== 1'b1) begin
      mismatched++; $display("FAIL reserved_111: got pc=%h fault=%b want %h 1", pc, fault, RV);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 3'b100, 8'h10, 1'b0);
    step(1'b1, 3'b100, 8'h20, 1'b0);
    step(1'b1, 3'b100, 8'h30, 1'b0);
    compared++;
    if (depth !== 3'd3) begin
      mismatched++; $display("FAIL pre_reset_depth: got %0d want 3", depth);
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (depth !== 3'd0 || pc !== RV || stack_empty !== 1'b1 || fault !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got depth=%0d pc=%h empty=%b fault=%b want 0 %h 1 0",
               depth, pc, stack_empty, fault, RV);
    end
    rst_n = 1'b1;
    step(1'b1, 3'b101, 8'h00, 1'b0);
    compared++;
    if (pc !== RV || fault !== 1'b1) begin
      mismatched++; $display("FAIL ret_after_reset: got pc=%h fault=%b want %h 1", pc, fault, RV);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 3'b010, 8'hFF, 1'b0);
    step(1'b1, 3'b100, 8'h10, 1'b0);
    step(1'b1, 3'b011, 8'h05, 1'b1);
    compared++;
    if (pc !== 8'h15 || depth !== 3'd1) begin
      mismatched++; $display("FAIL call_then_branch: got pc=%h depth=%0d want 15 1", pc, depth);
    end
    step(1'b1, 3'b101, 8'h00, 1'b0);
    compared++;
    if (pc !== 8'h00 || depth !== 3'd0 || fault !== 1'b0) begin
      mismatched++;
      $display("FAIL ret_wrapped: got pc=%h depth=%0d fault=%b want 00 0 0", pc, depth, fault);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_nested_calls();
    test_overflow();
    test_underflow();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the MIPS-style MPU core. It replaces the level-sensitive PC with a clocked register. It supports hold, sequential increment, absolute jump, conditional relative branch, and subroutine call/return through an internal return-address stack. It sits between instruction decode, which supplies `op`, `imm` and `taken`, and the instruction-memory address port, which consumes `pc`.

## Interface
Parameters:
- `WIDTH`, default 8: PC and immediate width in bits.
- `STACK_DEPTH`, default 4: number of return-address entries. Must be 1 or more.
- `RESET_VECTOR`, default 0: PC value loaded on reset, `WIDTH` bits.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  advance enable; 0 stalls the whole block.
- `op`  in  3  operation select; encodings are listed under Operation.
- `imm`  in  `WIDTH`  jump target, or signed branch offset.
- `taken`  in  1  branch condition; used only by BRANCH.
- `pc`  out  `WIDTH`  current program counter, registered.
- `depth`  out  `$clog2(STACK_DEPTH+1)`  number of occupied stack entries.
- `stack_full`  out  1  high when `depth == STACK_DEPTH`.
- `stack_empty`  out  1  high when `depth == 0`.
- `fault`  out  1  sticky error flag; cleared only by reset.

## Operation
Each rising edge with `en=1` and `rst_n=1` executes one `op`:
- `000` HOLD: `pc` unchanged.
- `001` NEXT: `pc <= pc + 1`.
- `010` JUMP: `pc <= imm`.
- `011` BRANCH:
  - `taken=1`: `pc <= pc + imm`, with `imm` treated as two's complement.
  - `taken=0`: `pc <= pc + 1`.
- `100` CALL: push `pc + 1` onto the stack, then `pc <= imm`.
- `101` RET: pop the top entry into `pc`.
- `110`, `111` reserved: `pc` unchanged and `fault <= 1`.

Arithmetic rules:
- All PC arithmetic is modulo 2^`WIDTH`; carries are discarded.
- Increment wraps, e.g. 0xFF + 1 = 0x00 for `WIDTH=8`.
- The pushed return address wraps the same way.

Stack behaviour:
- The stack is LIFO.
- Push writes entry[`depth`], then increments `depth`.
- Pop reads entry[`depth`-1], then decrements `depth`.
- Entry contents are not reset; only `depth` is.

Boundary conditions:
- CALL with `stack_full=1`: no push, `pc` unchanged, `depth` unchanged, `fault <= 1`.
- RET with `stack_empty=1`: `pc` unchanged, `depth` unchanged, `fault <= 1`.
- `en=0`: `pc`, `depth`, stack contents and `fault` all hold. `op`, `imm` and `taken` are ignored, including reserved encodings.
- `taken` is ignored for every op other than BRANCH.
- `fault` never clears while `rst_n=1`. Legal operations continue to execute normally after a fault.

## Timing
- Reset asserted (`rst_n=0`), asynchronous and independent of `clk`:
  - `pc = RESET_VECTOR`
  - `depth = 0`, so `stack_empty = 1` and `stack_full = 0`
  - `fault = 0`
- Reset asserted mid-sequence, e.g. inside nested calls, discards all stack state immediately.
- First update after reset: the first rising edge with `rst_n` sampled high executes `op`.
- Latency is one cycle. Inputs are sampled at edge N; the new `pc` is valid after edge N and held until edge N+1.
- Status outputs:
  - `depth`, `stack_full` and `stack_empty` are derived from the registered depth count, so they update with `pc`.
  - `fault` is a register and rises on the edge that executes the offending op.
- No combinational path exists from any input to `pc`, `depth` or `fault`.
- There is no handshake. Decode must present a valid `op` every cycle in which `en=1`.

## Test plan
- Reset and stall:
  - Drive `rst_n=0` mid-clock: `pc=RESET_VECTOR`, `depth=0`, `stack_empty=1`, `fault=0`, all without a clock edge.
  - Release reset and hold `en=0` with `op=001` for 5 cycles: `pc` stays at `RESET_VECTOR`.
- Wrap and branch (`WIDTH=8`):
  - From `pc=0xFE`, two NEXT ops: 0xFF, then 0x00.
  - From `pc=0x10`, BRANCH with `imm=0xFE`, `taken=1`: `pc=0x0E`.
  - Same BRANCH with `taken=0`: `pc=0x11`.
  - JUMP with `imm=0x40`: `pc=0x40`.
- Nested calls:
  - From `pc=0x05`, CALL 0x20: `pc=0x20`, `depth=1`.
  - CALL 0x30: `pc=0x30`, `depth=2`.
  - RET: `pc=0x21`, `depth=1`.
  - RET: `pc=0x06`, `depth=0`, `fault=0`.
- Stack overflow and underflow (`STACK_DEPTH=4`):
  - Five consecutive CALLs: the 5th leaves `pc` unchanged, `depth=4`, `stack_full=1`, `fault=1`.
  - After reset, RET on an empty stack: `pc` unchanged, `fault=1`.
  - Subsequent NEXT ops still increment `pc` while `fault` stays 1.
- Reserved op and reset mid-sequence:
  - `op=110`: `pc` holds and `fault=1`.
  - Same op with `en=0`: `fault` stays 0.
  - Pulse `rst_n` low at `depth=3`: `depth=0` and `pc=RESET_VECTOR` immediately.
  - A following RET flags `fault`.
